// File: rtl/fetch_ctrl.sv
// fetch_ctrl: instruction-fetch sequencer between the i$ (req/gnt/rvalid) and the re-aligner.
// Define FETCH_PREFETCH_EN for a 2-deep buffer and outstanding window; the default build is 1-deep.
//
// state | meaning
// RESET | in or just released from reset; flush held, no requests
// RUN   | issuing requests and delivering buffered words
// REDIR | one cycle after a redirect; flush pulse, request withdrawn
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        req_o,
    output logic [31:0] addr_o,
    input  logic        gnt_i,
    input  logic        rvalid_i,
    input  logic [31:0] rdata_i,
    output logic [31:0] word_o,
    output logic [31:0] word_addr_o,
    output logic        word_valid_o,
    input  logic        word_ready_i,
    output logic        start_hi_o,
    output logic        realign_flush_o
);

`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [2:0]  DEPTH_C    = 3'(DEPTH);
    localparam logic [31:0] RESET_ADDR = RESET_PC & ~32'h3;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_RUN   = 2'd1,
        ST_REDIR = 2'd2
    } state_e;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        hi;
    } entry_t;

    state_e      state_q, state_d;
    entry_t      buf_q [DEPTH];
    entry_t      buf_d [DEPTH];
    logic [1:0]  count_q, count_d;
    logic [1:0]  out_q, out_d;
    logic [3:0]  drop_q, drop_d;
    logic [31:0] next_addr_q, next_addr_d;
    logic [31:0] resp_addr_q, resp_addr_d;
    logic        pending_hi_q, pending_hi_d;
    logic        req_hold_q, req_hold_d;

    logic        pop;
    logic        fire;
    logic        rsp;
    logic        take;
    logic [2:0]  occ;
    logic [3:0]  inflight;
    logic [1:0]  wr_idx;
    logic [31:0] redirect_addr;

    assign word_valid_o  = (count_q != 2'd0);
    assign word_o        = buf_q[0].data;
    assign word_addr_o   = buf_q[0].addr;
    assign start_hi_o    = buf_q[0].hi;
    assign addr_o        = next_addr_q;

    assign pop           = word_valid_o && word_ready_i;
    assign fire          = req_o && gnt_i;
    assign occ           = {1'b0, out_q} + {1'b0, count_q};
    assign redirect_addr = redirect_pc_i & ~32'h3;

    // rsp: a response that belongs to some in-flight request; take: one that is kept.
    assign rsp      = rvalid_i && ((drop_q != 4'd0) || (out_q != 2'd0));
    assign take     = rvalid_i && (drop_q == 4'd0) && (out_q != 2'd0);
    assign inflight = drop_q + {2'b00, out_q} + {3'b000, fire} - {3'b000, rsp};
    assign wr_idx   = count_q - {1'b0, pop};

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_RESET;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (redirect_i) begin
            state_d = ST_REDIR;
        end else begin
            unique case (state_q)
                ST_RESET: state_d = ST_RUN;
                ST_RUN:   state_d = ST_RUN;
                ST_REDIR: state_d = ST_RUN;
                default:  state_d = ST_RESET;
            endcase
        end
    end

    // A word leaving this cycle frees its slot, which keeps the 1-word/cycle stream going;
    // an ungranted request is held so a stalled consumer cannot withdraw it.
    always_comb begin
        req_o           = 1'b0;
        realign_flush_o = 1'b1;
        if (state_q == ST_RUN) begin
            realign_flush_o = 1'b0;
            req_o           = req_hold_q || (occ < (DEPTH_C + {2'b00, pop}));
        end
    end

    // ---------------------------------------------------------------- datapath
    always_comb begin
        buf_d        = buf_q;
        count_d      = count_q;
        out_d        = out_q;
        drop_d       = drop_q;
        next_addr_d  = next_addr_q;
        resp_addr_d  = resp_addr_q;
        pending_hi_d = pending_hi_q;
        req_hold_d   = req_hold_q;

        if (redirect_i) begin
            count_d      = 2'd0;
            out_d        = 2'd0;
            drop_d       = inflight;
            next_addr_d  = redirect_addr;
            resp_addr_d  = redirect_addr;
            pending_hi_d = redirect_pc_i[1];
            req_hold_d   = 1'b0;
        end else begin
            if (pop) begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    buf_d[i] = buf_q[i + 1];
                end
            end
            if (take) begin
                for (int i = 0; i < DEPTH; i++) begin
                    if (2'(i) == wr_idx) begin
                        buf_d[i] = '{data: rdata_i, addr: resp_addr_q, hi: pending_hi_q};
                    end
                end
                resp_addr_d  = resp_addr_q + 32'd4;
                pending_hi_d = 1'b0;
            end
            count_d = count_q - {1'b0, pop} + {1'b0, take};
            out_d   = out_q + {1'b0, fire} - {1'b0, take};
            if (rvalid_i && (drop_q != 4'd0)) begin
                drop_d = drop_q - 4'd1;
            end
            if (fire) begin
                next_addr_d = next_addr_q + 32'd4;
            end
            req_hold_d = req_o && !gnt_i;
        end
    end

    // Responses still in flight at reset are counted into drop_q so they are discarded later.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            for (int i = 0; i < DEPTH; i++) begin
                buf_q[i] <= '0;
            end
            count_q      <= 2'd0;
            out_q        <= 2'd0;
            drop_q       <= inflight;
            next_addr_q  <= RESET_ADDR;
            resp_addr_q  <= RESET_ADDR;
            pending_hi_q <= RESET_PC[1];
            req_hold_q   <= 1'b0;
        end else begin
            buf_q        <= buf_d;
            count_q      <= count_d;
            out_q        <= out_d;
            drop_q       <= drop_d;
            next_addr_q  <= next_addr_d;
            resp_addr_q  <= resp_addr_d;
            pending_hi_q <= pending_hi_d;
            req_hold_q   <= req_hold_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// tb_fetch_ctrl: i$ model with 1-cycle response latency, expected-word queue per scenario.
// Works for both builds; FETCH_PREFETCH_EN selects the expected depth and throughput.
module tb_fetch_ctrl;
`ifdef FETCH_PREFETCH_EN
    localparam int DEPTH = 2;
`else
    localparam int DEPTH = 1;
`endif
    localparam logic [31:0] RESET_PC = 32'h0000_0100;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        redirect_i = 1'b0;
    logic [31:0] redirect_pc_i = '0;
    logic        req_o;
    logic [31:0] addr_o;
    logic        gnt_i;
    logic        rvalid_i = 1'b0;
    logic [31:0] rdata_i = '0;
    logic [31:0] word_o;
    logic [31:0] word_addr_o;
    logic        word_valid_o;
    logic        word_ready_i = 1'b1;
    logic        start_hi_o;
    logic        realign_flush_o;

    always #5 clk_i = ~clk_i;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .redirect_i     (redirect_i),
        .redirect_pc_i  (redirect_pc_i),
        .req_o          (req_o),
        .addr_o         (addr_o),
        .gnt_i          (gnt_i),
        .rvalid_i       (rvalid_i),
        .rdata_i        (rdata_i),
        .word_o         (word_o),
        .word_addr_o    (word_addr_o),
        .word_valid_o   (word_valid_o),
        .word_ready_i   (word_ready_i),
        .start_hi_o     (start_hi_o),
        .realign_flush_o(realign_flush_o)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] addr;
        logic        hi;
        int          cyc;
    } obs_t;

    typedef struct {
        logic [31:0] addr;
        logic        hi;
    } exp_t;

    obs_t        got_q[$];
    exp_t        exp_q[$];
    logic [31:0] ic_q[$];
    logic [31:0] gnt_log[$];

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    logic gnt_en  = 1'b0;
    logic rsp_hold = 1'b0;

    logic        s_req, s_flush, s_valid, s_hi;
    logic [31:0] s_addr, s_word, s_waddr;

    assign gnt_i = gnt_en;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h3C5A_96E1;
    endfunction

    function automatic exp_t mk(input logic [31:0] a, input logic hi);
        exp_t e;
        e.addr = a;
        e.hi   = hi;
        return e;
    endfunction

    // One clock cycle: deliver the oldest granted block, then sample the cycle's outputs.
    task automatic step();
        obs_t o;
        rvalid_i = 1'b0;
        rdata_i  = '0;
        if (!rsp_hold && ic_q.size() != 0) begin
            rdata_i  = mem(ic_q.pop_front());
            rvalid_i = 1'b1;
        end
        #1;
        s_req   = req_o;
        s_addr  = addr_o;
        s_flush = realign_flush_o;
        s_valid = word_valid_o;
        s_word  = word_o;
        s_waddr = word_addr_o;
        s_hi    = start_hi_o;
        if (req_o && gnt_i) begin
            ic_q.push_back(addr_o);
            gnt_log.push_back(addr_o);
        end
        if (word_valid_o && word_ready_i) begin
            o.data = word_o;
            o.addr = word_addr_o;
            o.hi   = start_hi_o;
            o.cyc  = cyc;
            got_q.push_back(o);
        end
        @(negedge clk_i);
        cyc++;
    endtask

    task automatic run_until(input int n, input int budget);
        for (int k = 0; k < budget && got_q.size() < n; k++) step();
    endtask

    // Reset, let stale responses drain into the drop counter, then clear the bench queues.
    task automatic do_reset();
        gnt_en       = 1'b0;
        rsp_hold     = 1'b0;
        redirect_i   = 1'b0;
        word_ready_i = 1'b1;
        rst_ni       = 1'b0;
        step();
        step();
        rst_ni = 1'b1;
        for (int k = 0; k < 4; k++) step();
        got_q.delete();
        gnt_log.delete();
        exp_q.delete();
        gnt_en = 1'b1;
    endtask

    task automatic test_reset();
        rst_ni       = 1'b0;
        gnt_en       = 1'b1;
        word_ready_i = 1'b1;
        step();
        step();
        step();
        n_tests++;
        if ({s_req, s_flush, s_valid, s_hi} !== 4'b0100) begin
            n_fail++;
            $display("FAIL reset_ctrl: req/flush/valid/hi = %b, required 0100", {s_req, s_flush, s_valid, s_hi});
        end
        n_tests++;
        if (s_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL reset_addr: addr_o = %h, required 00000100", s_addr);
        end
        n_tests++;
        if (s_word !== 32'h0 || s_waddr !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_word: word_o = %h word_addr_o = %h, required 0 and 0", s_word, s_waddr);
        end
        rst_ni = 1'b1;
        step();
        n_tests++;
        if (s_req !== 1'b0 || s_flush !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release: req = %b flush = %b, required req 0 flush 1", s_req, s_flush);
        end
        step();
        n_tests++;
        if (s_req !== 1'b1 || s_flush !== 1'b0 || s_addr !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL first_req: req = %b flush = %b addr = %h, required 1 0 00000100", s_req, s_flush, s_addr);
        end
    endtask

    task automatic test_stream();
        obs_t g;
        exp_t e;
        int   first_cyc;
        int   last_cyc;
        for (int k = 0; k < 8; k++) exp_q.push_back(mk(32'h100 + 32'(4 * k), 1'b0));
        run_until(8, 60);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (gnt_log.size() <= k) begin
                n_fail++;
                $display("FAIL stream_addr%0d: no grant seen, required %h", k, 32'h100 + 32'(4 * k));
            end else if (gnt_log[k] !== 32'h100 + 32'(4 * k)) begin
                n_fail++;
                $display("FAIL stream_addr%0d: addr_o = %h, required %h", k, gnt_log[k], 32'h100 + 32'(4 * k));
            end
        end
        first_cyc = -1;
        last_cyc  = -1;
        for (int k = 0; k < 8; k++) begin
            n_tests++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stream_word%0d: word not delivered", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (k == 0) first_cyc = g.cyc;
                last_cyc = g.cyc;
                if (g.addr !== e.addr || g.data !== mem(e.addr) || g.hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL stream_word%0d: got addr %h data %h hi %b, required addr %h data %h hi %b",
                             k, g.addr, g.data, g.hi, e.addr, mem(e.addr), e.hi);
                end
            end
        end
        n_tests++;
        if (last_cyc - first_cyc !== (DEPTH == 2 ? 7 : 14)) begin
            n_fail++;
            $display("FAIL stream_rate: 8 words span %0d cycles, required %0d", last_cyc - first_cyc, (DEPTH == 2 ? 7 : 14));
        end
    endtask

    task automatic test_backpressure();
        obs_t g;
        exp_t e;
        do_reset();
        for (int k = 0; k < 6; k++) exp_q.push_back(mk(32'h100 + 32'(4 * k), 1'b0));
        word_ready_i = 1'b0;
        for (int k = 0; k < 8; k++) step();
        n_tests++;
        if (s_req !== 1'b0 || s_valid !== 1'b1 || gnt_log.size() !== DEPTH) begin
            n_fail++;
            $display("FAIL stall_full: req = %b valid = %b grants = %0d, required 0 1 %0d", s_req, s_valid, gnt_log.size(), DEPTH);
        end
        for (int k = 0; k < 5; k++) begin
            step();
            n_tests++;
            if (s_word !== mem(32'h100) || s_waddr !== 32'h100 || s_req !== 1'b0) begin
                n_fail++;
                $display("FAIL stall_hold%0d: word %h addr %h req %b, required %h 00000100 0", k, s_word, s_waddr, s_req, mem(32'h100));
            end
        end
        word_ready_i = 1'b1;
        run_until(6, 40);
        for (int k = 0; k < 6; k++) begin
            n_tests++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL stall_word%0d: word not delivered", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g.addr !== e.addr || g.data !== mem(e.addr) || g.hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL stall_word%0d: got addr %h data %h hi %b, required addr %h data %h hi %b",
                             k, g.addr, g.data, g.hi, e.addr, mem(e.addr), e.hi);
                end
            end
        end
    endtask

    task automatic test_redirect_drop();
        obs_t g;
        exp_t e;
        do_reset();
        rsp_hold = 1'b1;
        for (int k = 0; k < 4; k++) step();
        redirect_pc_i = 32'h0000_2002;
        redirect_i    = 1'b1;
        step();
        redirect_i = 1'b0;
        rsp_hold   = 1'b0;
        step();
        n_tests++;
        if (s_flush !== 1'b1 || s_req !== 1'b0 || s_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_n1: flush %b req %b valid %b, required 1 0 0", s_flush, s_req, s_valid);
        end
        step();
        n_tests++;
        if (s_flush !== 1'b0) begin
            n_fail++;
            $display("FAIL redir_flush_pulse: flush = %b at N+2, required 0", s_flush);
        end
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_2000) begin
            n_fail++;
            $display("FAIL redir_n2: req %b addr %h, required 1 00002000", s_req, s_addr);
        end
        exp_q.push_back(mk(32'h2000, 1'b1));
        exp_q.push_back(mk(32'h2004, 1'b0));
        exp_q.push_back(mk(32'h2008, 1'b0));
        run_until(3, 40);
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL redir_word%0d: word not delivered", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g.addr !== e.addr || g.data !== mem(e.addr) || g.hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL redir_word%0d: got addr %h data %h hi %b, required addr %h data %h hi %b",
                             k, g.addr, g.data, g.hi, e.addr, mem(e.addr), e.hi);
                end
            end
        end
    endtask

    task automatic test_redirect_ungranted();
        obs_t g;
        exp_t e;
        do_reset();
        gnt_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_tests++;
            if (s_req !== 1'b1 || s_addr !== 32'h0000_0100) begin
                n_fail++;
                $display("FAIL ungnt_hold%0d: req %b addr %h, required 1 00000100", k, s_req, s_addr);
            end
        end
        redirect_pc_i = 32'h0000_3000;
        redirect_i    = 1'b1;
        step();
        redirect_i = 1'b0;
        gnt_en     = 1'b1;
        step();
        n_tests++;
        if (s_req !== 1'b0) begin
            n_fail++;
            $display("FAIL ungnt_withdraw: req = %b at N+1, required 0", s_req);
        end
        step();
        n_tests++;
        if (s_req !== 1'b1 || s_addr !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL ungnt_reissue: req %b addr %h at N+2, required 1 00003000", s_req, s_addr);
        end
        exp_q.push_back(mk(32'h3000, 1'b0));
        exp_q.push_back(mk(32'h3004, 1'b0));
        run_until(2, 30);
        n_tests++;
        if (gnt_log.size() == 0 || gnt_log[0] !== 32'h0000_3000) begin
            n_fail++;
            $display("FAIL ungnt_first_grant: %0d grants, first %h, required first 00003000",
                     gnt_log.size(), (gnt_log.size() == 0) ? 32'h0 : gnt_log[0]);
        end
        for (int k = 0; k < 2; k++) begin
            n_tests++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL ungnt_word%0d: word not delivered", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g.addr !== e.addr || g.data !== mem(e.addr) || g.hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL ungnt_word%0d: got addr %h data %h hi %b, required addr %h data %h hi %b",
                             k, g.addr, g.data, g.hi, e.addr, mem(e.addr), e.hi);
                end
            end
        end
    endtask

    task automatic test_wrap();
        obs_t g;
        exp_t e;
        do_reset();
        redirect_pc_i = 32'hFFFF_FFFC;
        redirect_i    = 1'b1;
        step();
        redirect_i = 1'b0;
        gnt_log.delete();
        got_q.delete();
        exp_q.push_back(mk(32'hFFFF_FFFC, 1'b0));
        exp_q.push_back(mk(32'h0000_0000, 1'b0));
        exp_q.push_back(mk(32'h0000_0004, 1'b0));
        run_until(3, 30);
        n_tests++;
        if (gnt_log.size() < 2 || gnt_log[0] !== 32'hFFFF_FFFC || gnt_log[1] !== 32'h0) begin
            n_fail++;
            $display("FAIL wrap_addr: %0d grants, second %h, required FFFFFFFC then 00000000",
                     gnt_log.size(), (gnt_log.size() < 2) ? 32'hX : gnt_log[1]);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL wrap_word%0d: word not delivered", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g.addr !== e.addr || g.data !== mem(e.addr) || g.hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL wrap_word%0d: got addr %h data %h hi %b, required addr %h data %h hi %b",
                             k, g.addr, g.data, g.hi, e.addr, mem(e.addr), e.hi);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        obs_t g;
        exp_t e;
        do_reset();
        for (int k = 0; k < 4; k++) step();
        rsp_hold = 1'b1;
        for (int k = 0; k < 3; k++) step();
        rst_ni = 1'b0;
        gnt_en = 1'b0;
        step();
        rst_ni = 1'b1;
        gnt_en = 1'b1;
        got_q.delete();
        gnt_log.delete();
        exp_q.delete();
        for (int k = 0; k < 3; k++) exp_q.push_back(mk(32'h100 + 32'(4 * k), 1'b0));
        for (int k = 0; k < 4; k++) step();
        rsp_hold = 1'b0;
        run_until(3, 40);
        n_tests++;
        if (gnt_log.size() == 0 || gnt_log[0] !== 32'h0000_0100) begin
            n_fail++;
            $display("FAIL midrst_restart: %0d grants, first %h, required first 00000100",
                     gnt_log.size(), (gnt_log.size() == 0) ? 32'h0 : gnt_log[0]);
        end
        for (int k = 0; k < 3; k++) begin
            n_tests++;
            if (got_q.size() == 0 || exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL midrst_word%0d: word not delivered", k);
            end else begin
                g = got_q.pop_front();
                e = exp_q.pop_front();
                if (g.addr !== e.addr || g.data !== mem(e.addr) || g.hi !== e.hi) begin
                    n_fail++;
                    $display("FAIL midrst_word%0d: got addr %h data %h hi %b, required addr %h data %h hi %b",
                             k, g.addr, g.data, g.hi, e.addr, mem(e.addr), e.hi);
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect_drop();
        test_redirect_ungranted();
        test_wrap();
        test_reset_midop();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
